// File: rtl/mem_pattern_checker.sv
// Avalon-MM traffic engine: writes and/or reads pattern bursts from a base address
// and checks every returned read word, with multiple outstanding read bursts.
module mem_pattern_checker #(
  parameter int unsigned AMM_ADDR_W  = 31,
  parameter int unsigned AMM_DATA_W  = 128,
  parameter int unsigned AMM_BURST_W = 11,
  parameter int unsigned MAX_RD_OUT  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  input  logic [1:0]              pattern_i,
  input  logic [31:0]             seed_i,
  input  logic [AMM_ADDR_W-1:0]   base_addr_i,
  input  logic [AMM_BURST_W-1:0]  burst_len_i,
  input  logic [15:0]             burst_cnt_i,
  input  logic                    stop_on_err_i,
  output logic [AMM_ADDR_W-1:0]   address_o,
  output logic                    read_o,
  output logic                    write_o,
  output logic [AMM_DATA_W-1:0]   writedata_o,
  output logic [AMM_BURST_W-1:0]  burstcount_o,
  output logic [AMM_DATA_W/8-1:0] byteenable_o,
  input  logic                    waitrequest_i,
  input  logic                    readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]   readdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [31:0]             err_cnt_o,
  output logic [AMM_ADDR_W-1:0]   err_addr_o,
  output logic [31:0]             err_data_o
);

  localparam int unsigned LANES = AMM_DATA_W / 32;
  localparam int unsigned OUT_W = $clog2(MAX_RD_OUT + 1);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Lane value for one word; the LFSR state is that word's value, k is the word index mod 32.
  function automatic logic [31:0] f_lane(input logic [1:0] pat, input logic [31:0] seed,
                                         input logic [31:0] lfsr, input logic [AMM_ADDR_W-1:0] addr,
                                         input logic [4:0] k);
    logic [31:0] v;
    case (pat)
      2'd0:    v = seed;
      2'd1:    v = 32'(addr);
      2'd2:    v = lfsr;
      default: v = 32'h1 << k;
    endcase
    return v;
  endfunction

  state_t                 r_state;
  logic [1:0]             r_mode;
  logic [1:0]             r_pattern;
  logic [31:0]            r_seed;
  logic [AMM_ADDR_W-1:0]  r_base;
  logic [AMM_BURST_W-1:0] r_len;
  logic [15:0]            r_cnt;
  logic                   r_stop;
  logic [AMM_BURST_W-1:0] r_wr_beat;
  logic [15:0]            r_wr_burst;
  logic [AMM_ADDR_W-1:0]  r_wg_addr;
  logic [31:0]            r_wg_lfsr;
  logic [4:0]             r_wg_k;
  logic [AMM_ADDR_W-1:0]  r_eg_addr;
  logic [31:0]            r_eg_lfsr;
  logic [4:0]             r_eg_k;
  logic [AMM_ADDR_W-1:0]  r_rd_addr;
  logic [15:0]            r_rd_put;
  logic [OUT_W-1:0]       r_out;
  logic [AMM_BURST_W-1:0] r_rx_beat;

  logic [31:0]            w_seed;
  logic [AMM_BURST_W-1:0] w_len;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_rx;
  logic                   w_rx_last;
  logic [OUT_W-1:0]       w_out_next;
  logic [AMM_DATA_W-1:0]  w_exp;
  logic                   w_mis;
  logic                   w_stop;
  logic                   w_can_issue;
  logic                   w_wr_last;
  logic [AMM_DATA_W-1:0]  w_wr_first;
  logic [AMM_DATA_W-1:0]  w_wr_next;

  assign w_seed      = (seed_i == 32'd0) ? 32'h1 : seed_i;
  assign w_len       = (burst_len_i == '0) ? AMM_BURST_W'(1) : burst_len_i;
  assign w_wr_acc    = write_o && !waitrequest_i;
  assign w_rd_acc    = read_o && !waitrequest_i;
  assign w_rx        = readdatavalid_i && ((r_state == S_RD) || (r_state == S_DRAIN));
  assign w_rx_last   = w_rx && (r_rx_beat == r_len - AMM_BURST_W'(1));
  assign w_out_next  = r_out + OUT_W'(w_rd_acc) - OUT_W'(w_rx_last);
  assign w_exp       = {LANES{f_lane(r_pattern, r_seed, r_eg_lfsr, r_eg_addr, r_eg_k)}};
  assign w_mis       = w_rx && (readdata_i != w_exp);
  // A mismatch in this very cycle already blocks the next read issue.
  assign w_stop      = r_stop && (error_o || w_mis);
  assign w_can_issue = (r_rd_put != r_cnt) && !w_stop && (w_out_next < OUT_W'(MAX_RD_OUT));
  assign w_wr_last   = (r_wr_beat == r_len - AMM_BURST_W'(1)) && (r_wr_burst == r_cnt - 16'd1);
  assign w_wr_first  = {LANES{f_lane(pattern_i, w_seed, w_seed, base_addr_i, 5'd0)}};
  assign w_wr_next   = {LANES{f_lane(r_pattern, r_seed, f_lfsr_step(r_wg_lfsr),
                                     r_wg_addr + AMM_ADDR_W'(1), r_wg_k + 5'd1)}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_mode <= '0; r_pattern <= '0; r_seed <= '0; r_base <= '0; r_len <= '0;
      r_cnt <= '0; r_stop <= 1'b0;
      r_wr_beat <= '0; r_wr_burst <= '0; r_wg_addr <= '0; r_wg_lfsr <= '0; r_wg_k <= '0;
      r_eg_addr <= '0; r_eg_lfsr <= '0; r_eg_k <= '0;
      r_rd_addr <= '0; r_rd_put <= '0; r_out <= '0; r_rx_beat <= '0;
      address_o <= '0; read_o <= 1'b0; write_o <= 1'b0; writedata_o <= '0;
      burstcount_o <= '0; byteenable_o <= '0;
      busy_o <= 1'b0; done_o <= 1'b0; error_o <= 1'b0;
      err_cnt_o <= '0; err_addr_o <= '0; err_data_o <= '0;
    end else begin
      done_o <= 1'b0;
      r_out  <= w_out_next;
      // Read-return checker; beats arrive in issue order so the expected generator just steps.
      if (w_rx) begin
        r_rx_beat <= w_rx_last ? '0 : r_rx_beat + AMM_BURST_W'(1);
        r_eg_addr <= r_eg_addr + AMM_ADDR_W'(1);
        r_eg_lfsr <= f_lfsr_step(r_eg_lfsr);
        r_eg_k    <= r_eg_k + 5'd1;
        if (w_mis) begin
          error_o <= 1'b1;
          if (err_cnt_o != 32'hFFFF_FFFF) err_cnt_o <= err_cnt_o + 32'd1;
          if (!error_o) begin
            err_addr_o <= r_eg_addr;
            err_data_o <= readdata_i[31:0];
          end
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode <= mode_i; r_pattern <= pattern_i; r_seed <= w_seed; r_base <= base_addr_i;
            r_len <= w_len; r_cnt <= burst_cnt_i; r_stop <= stop_on_err_i;
            error_o <= 1'b0; err_cnt_o <= '0; err_addr_o <= '0; err_data_o <= '0;
            r_eg_addr <= base_addr_i; r_eg_lfsr <= w_seed; r_eg_k <= '0;
            r_out <= '0; r_rx_beat <= '0;
            busy_o <= 1'b1;
            burstcount_o <= w_len;
            address_o <= base_addr_i;
            if (burst_cnt_i == 16'd0) begin
              r_state <= S_DONE;
              done_o  <= 1'b1;
            end else if (mode_i == 2'd1) begin
              r_state <= S_RD;
              read_o <= 1'b1; byteenable_o <= '1;
              r_rd_addr <= base_addr_i + AMM_ADDR_W'(w_len);
              r_rd_put  <= 16'd1;
            end else begin
              r_state <= S_WR;
              write_o <= 1'b1; byteenable_o <= '1;
              writedata_o <= w_wr_first;
              r_wg_addr <= base_addr_i; r_wg_lfsr <= w_seed; r_wg_k <= '0;
              r_wr_beat <= '0; r_wr_burst <= '0;
            end
          end
        end
        S_WR: begin
          if (w_wr_acc) begin
            if (w_wr_last) begin
              write_o <= 1'b0;
              if (r_mode == 2'd0) begin
                byteenable_o <= '0;
                r_state <= S_DONE;
                done_o  <= 1'b1;
              end else begin
                r_state <= S_RD;
                read_o <= 1'b1;
                address_o <= r_base;
                r_rd_addr <= r_base + AMM_ADDR_W'(r_len);
                r_rd_put  <= 16'd1;
              end
            end else begin
              r_wg_addr <= r_wg_addr + AMM_ADDR_W'(1);
              r_wg_lfsr <= f_lfsr_step(r_wg_lfsr);
              r_wg_k    <= r_wg_k + 5'd1;
              writedata_o <= w_wr_next;
              // Burst address is presented for the whole burst and moves only at a burst boundary.
              if (r_wr_beat == r_len - AMM_BURST_W'(1)) begin
                r_wr_beat  <= '0;
                r_wr_burst <= r_wr_burst + 16'd1;
                address_o  <= r_wg_addr + AMM_ADDR_W'(1);
              end else begin
                r_wr_beat <= r_wr_beat + AMM_BURST_W'(1);
              end
            end
          end
        end
        S_RD: begin
          if (!read_o || w_rd_acc) begin
            if (w_can_issue) begin
              read_o <= 1'b1; byteenable_o <= '1;
              address_o <= r_rd_addr;
              r_rd_addr <= r_rd_addr + AMM_ADDR_W'(r_len);
              r_rd_put  <= r_rd_put + 16'd1;
            end else begin
              read_o <= 1'b0; byteenable_o <= '0;
              if ((r_rd_put == r_cnt) || w_stop) r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_out_next == '0) begin
            r_state <= S_DONE;
            done_o  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pattern_checker.sv
// Self-checking bench for mem_pattern_checker: Avalon memory responder plus a pattern
// reference computed word-by-word from the pattern rules.
module tb_mem_pattern_checker;
  localparam int unsigned AW = 31;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 11;
  localparam int unsigned MRO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] mode_i = '0, pattern_i = '0;
  logic [31:0] seed_i = '0;
  logic [AW-1:0] base_addr_i = '0;
  logic [BW-1:0] burst_len_i = '0;
  logic [15:0] burst_cnt_i = '0;
  logic stop_on_err_i = 1'b0;
  logic [AW-1:0] address_o;
  logic read_o, write_o;
  logic [DW-1:0] writedata_o;
  logic [BW-1:0] burstcount_o;
  logic [DW/8-1:0] byteenable_o;
  logic waitrequest_i = 1'b0, readdatavalid_i = 1'b0;
  logic [DW-1:0] readdata_i = '0;
  logic busy_o, done_o, error_o;
  logic [31:0] err_cnt_o, err_data_o;
  logic [AW-1:0] err_addr_o;

  mem_pattern_checker #(.AMM_ADDR_W(AW), .AMM_DATA_W(DW), .AMM_BURST_W(BW), .MAX_RD_OUT(MRO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .mode_i(mode_i), .pattern_i(pattern_i),
    .seed_i(seed_i), .base_addr_i(base_addr_i), .burst_len_i(burst_len_i), .burst_cnt_i(burst_cnt_i),
    .stop_on_err_i(stop_on_err_i), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .writedata_o(writedata_o), .burstcount_o(burstcount_o), .byteenable_o(byteenable_o),
    .waitrequest_i(waitrequest_i), .readdatavalid_i(readdatavalid_i), .readdata_i(readdata_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_cnt_o(err_cnt_o),
    .err_addr_o(err_addr_o), .err_data_o(err_data_o));

  int unsigned n_vec = 0, n_bad = 0;

  // Reference lane value of word k of a phase, straight from the pattern definitions.
  function automatic logic [31:0] ref_lane(input int unsigned p, input logic [31:0] seed,
                                           input logic [AW-1:0] base, input int unsigned k);
    logic [31:0] v;
    logic [AW-1:0] a;
    v = (seed == 32'd0) ? 32'h1 : seed;
    case (p)
      0: ;
      1: begin a = base + AW'(k); v = {1'b0, a}; end
      2: for (int unsigned i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
      default: v = 32'h1 << (k % 32);
    endcase
    return v;
  endfunction

  // Memory / bus responder state
  typedef struct { logic [AW-1:0] addr; int unsigned ready; bit last; } beat_t;
  logic [DW-1:0] mem [int unsigned];
  beat_t pend[$];
  logic [AW-1:0] wlog_addr[$];
  logic [DW-1:0] wlog_data[$];
  int unsigned cyc = 0, lat = 2, tail_ready = 0;
  bit stall_en = 0, corrupt_en = 0;
  logic [AW-1:0] corrupt_addr = '0;
  int unsigned wr_beat = 0, n_rd_acc = 0, n_beats = 0, n_done = 0;
  int unsigned out_cnt = 0, max_out = 0, hold_viol = 0, rd_after_err = 0;
  logic [AW-1:0] wr_base = '0;
  bit prev_wstall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    beat_t b;
    logic [AW-1:0] wa;
    int unsigned st;
    cyc++;
    if (rst) begin
      waitrequest_i = 1'b0; readdatavalid_i = 1'b0;
      pend.delete(); out_cnt = 0; wr_beat = 0; prev_wstall = 0; tail_ready = cyc;
    end else begin
      if (prev_wstall && (!write_o || address_o !== prev_addr || writedata_o !== prev_data)) hold_viol++;
      if (read_o && error_o) rd_after_err++;
      if (done_o) n_done++;
      waitrequest_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (write_o && !waitrequest_i) begin
        if (wr_beat == 0) wr_base = address_o;
        wa = wr_base + AW'(wr_beat);
        wlog_addr.push_back(wa); wlog_data.push_back(writedata_o);
        mem[{1'b0, wa}] = writedata_o;
        wr_beat++;
        if (wr_beat == int'(burstcount_o)) wr_beat = 0;
      end
      prev_wstall = write_o && waitrequest_i;
      prev_addr = address_o; prev_data = writedata_o;
      if (read_o && !waitrequest_i) begin
        n_rd_acc++; out_cnt++;
        if (out_cnt > max_out) max_out = out_cnt;
        st = (cyc + lat > tail_ready) ? cyc + lat : tail_ready + 1;
        for (int unsigned i = 0; i < int'(burstcount_o); i++) begin
          b.addr = address_o + AW'(i); b.ready = st + i; b.last = (i == int'(burstcount_o) - 1);
          pend.push_back(b);
        end
        tail_ready = st + int'(burstcount_o) - 1;
      end
      if (pend.size() > 0 && pend[0].ready <= cyc) begin
        b = pend.pop_front();
        readdatavalid_i = 1'b1;
        readdata_i = mem.exists({1'b0, b.addr}) ? mem[{1'b0, b.addr}] : '0;
        if (corrupt_en && b.addr == corrupt_addr) readdata_i[31:0] = 32'd0;
        n_beats++;
        if (b.last) out_cnt--;
      end else begin
        readdatavalid_i = 1'b0;
        readdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clr_model();
    wlog_addr.delete(); wlog_data.delete();
    n_rd_acc = 0; n_beats = 0; n_done = 0; max_out = 0; hold_viol = 0; rd_after_err = 0;
    corrupt_en = 0; stall_en = 0;
  endtask

  task automatic prefill(input int unsigned p, input logic [31:0] s, input logic [AW-1:0] base,
                         input int unsigned n);
    logic [AW-1:0] a;
    for (int unsigned k = 0; k < n; k++) begin
      a = base + AW'(k);
      mem[{1'b0, a}] = {4{ref_lane(p, s, base, k)}};
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [1:0] p, input logic [31:0] s,
                           input logic [AW-1:0] b, input logic [BW-1:0] l, input logic [15:0] c,
                           input logic stop);
    mode_i = m; pattern_i = p; seed_i = s; base_addr_i = b; burst_len_i = l; burst_cnt_i = c;
    stop_on_err_i = stop; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output bit seen);
    seen = 0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      if (done_o) seen = 1; else tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++; if ({read_o, write_o, busy_o, done_o, error_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b required 00000", {read_o, write_o, busy_o, done_o, error_o}); end
    n_vec++; if (address_o !== '0 || burstcount_o !== '0 || byteenable_o !== '0 || writedata_o !== '0) begin
      n_bad++; $display("FAIL reset_bus: addr %h bc %h be %h wd %h required all 0", address_o, burstcount_o, byteenable_o, writedata_o); end
    n_vec++; if (err_cnt_o !== '0 || err_addr_o !== '0 || err_data_o !== '0) begin
      n_bad++; $display("FAIL reset_status: cnt %h addr %h data %h required 0", err_cnt_o, err_addr_o, err_data_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read_ideal();
    bit seen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    clr_model(); lat = 3;
    start_run(2'd2, 2'd1, 32'h0, AW'(32'h100), BW'(4), 16'd2, 1'b0);
    wait_done(500, seen);
    n_vec++; if (!seen) begin n_bad++; $display("FAIL ideal_done: done_o not seen"); end
    n_vec++; if (error_o !== 1'b0 || err_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL ideal_status: error %b cnt %0d required 0 0", error_o, err_cnt_o); end
    n_vec++; if (wlog_addr.size() != 8) begin
      n_bad++; $display("FAIL ideal_wr_count: got %0d required 8", wlog_addr.size()); end
    for (int unsigned i = 0; i < wlog_addr.size() && i < 8; i++) begin
      ea = AW'(32'h100 + i); ed = {4{ref_lane(1, 32'h0, AW'(32'h100), i)}};
      n_vec++; if (wlog_addr[i] !== ea || wlog_data[i] !== ed) begin
        n_bad++; $display("FAIL ideal_wr[%0d]: got %h/%h required %h/%h", i, wlog_addr[i], wlog_data[i], ea, ed); end
    end
    tick(); tick();
    n_vec++; if (n_done != 1 || n_beats != 8 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL ideal_pulse: done %0d beats %0d busy %b required 1 8 0", n_done, n_beats, busy_o); end
  endtask

  task automatic test_corrupt_word();
    bit seen;
    clr_model(); lat = 3; corrupt_en = 1; corrupt_addr = AW'(32'h105);
    start_run(2'd2, 2'd1, 32'h0, AW'(32'h100), BW'(4), 16'd2, 1'b0);
    wait_done(500, seen);
    n_vec++; if (!seen) begin n_bad++; $display("FAIL corrupt_done: done_o not seen"); end
    n_vec++; if (error_o !== 1'b1 || err_cnt_o !== 32'd1) begin
      n_bad++; $display("FAIL corrupt_cnt: error %b cnt %0d required 1 1", error_o, err_cnt_o); end
    n_vec++; if (err_addr_o !== AW'(32'h105) || err_data_o !== 32'd0) begin
      n_bad++; $display("FAIL corrupt_capture: addr %h data %h required 105 0", err_addr_o, err_data_o); end
    tick(); tick();
  endtask

  task automatic test_outstanding();
    bit seen;
    logic [AW-1:0] b;
    clr_model(); lat = 20;
    b = AW'($urandom);
    prefill(3, 32'h0, b, 10);
    start_run(2'd1, 2'd3, 32'h0, b, BW'(1), 16'd10, 1'b0);
    wait_done(1000, seen);
    n_vec++; if (!seen) begin n_bad++; $display("FAIL outst_done: done_o not seen"); end
    n_vec++; if (max_out != MRO) begin
      n_bad++; $display("FAIL outst_max: peak %0d required %0d", max_out, MRO); end
    n_vec++; if (n_beats != 10 || n_rd_acc != 10 || error_o !== 1'b0) begin
      n_bad++; $display("FAIL outst_beats: beats %0d reads %0d err %b required 10 10 0", n_beats, n_rd_acc, error_o); end
    tick(); tick();
  endtask

  task automatic test_lfsr_stall();
    bit seen;
    logic [AW-1:0] b, ea;
    logic [DW-1:0] ed;
    clr_model(); stall_en = 1;
    b = AW'($urandom);
    start_run(2'd0, 2'd2, 32'h0, b, BW'(5), 16'd3, 1'b0);
    wait_done(1000, seen);
    n_vec++; if (!seen) begin n_bad++; $display("FAIL lfsr_done: done_o not seen"); end
    n_vec++; if (wlog_addr.size() != 15 || hold_viol != 0) begin
      n_bad++; $display("FAIL lfsr_count_hold: writes %0d hold_viol %0d required 15 0", wlog_addr.size(), hold_viol); end
    for (int unsigned i = 0; i < wlog_addr.size() && i < 15; i++) begin
      ea = b + AW'(i); ed = {4{ref_lane(2, 32'h1, b, i)}};
      n_vec++; if (wlog_addr[i] !== ea || wlog_data[i] !== ed) begin
        n_bad++; $display("FAIL lfsr_wr[%0d]: got %h/%h required %h/%h", i, wlog_addr[i], wlog_data[i], ea, ed); end
    end
    tick(); tick();
  endtask

  task automatic test_stop_on_err();
    bit seen;
    logic [AW-1:0] b;
    clr_model(); lat = 3;
    b = AW'($urandom);
    corrupt_en = 1; corrupt_addr = b;
    start_run(2'd2, 2'd0, $urandom | 32'h1, b, BW'(2), 16'd8, 1'b1);
    wait_done(1000, seen);
    n_vec++; if (!seen) begin n_bad++; $display("FAIL stop_done: done_o not seen"); end
    n_vec++; if (error_o !== 1'b1 || err_cnt_o < 32'd1 || err_addr_o !== b) begin
      n_bad++; $display("FAIL stop_status: err %b cnt %0d addr %h required 1 >=1 %h", error_o, err_cnt_o, err_addr_o, b); end
    n_vec++; if (rd_after_err != 0 || n_rd_acc >= 8) begin
      n_bad++; $display("FAIL stop_reads: read_o after error %0d, reads %0d required 0 and <8", rd_after_err, n_rd_acc); end
    n_vec++; if (n_beats != 2 * n_rd_acc) begin
      n_bad++; $display("FAIL stop_drain: beats %0d required %0d", n_beats, 2 * n_rd_acc); end
    tick(); tick();
  endtask

  task automatic test_busy_reset_zero();
    bit seen;
    logic [AW-1:0] ea;
    clr_model();
    start_run(2'd0, 2'd1, 32'h0, AW'(32'h40), BW'(4), 16'd4, 1'b0);
    tick(); tick();
    start_run(2'd1, 2'd0, 32'h5, AW'(32'h900), BW'(1), 16'd1, 1'b0);
    wait_done(500, seen);
    tick(); tick();
    n_vec++; if (!seen || n_done != 1 || wlog_addr.size() != 16 || n_rd_acc != 0) begin
      n_bad++; $display("FAIL busy_ignore: done %0d writes %0d reads %0d required 1 16 0", n_done, wlog_addr.size(), n_rd_acc); end
    ea = AW'(32'h4F);
    n_vec++; if (wlog_addr.size() == 16 && wlog_addr[15] !== ea) begin
      n_bad++; $display("FAIL busy_last_addr: got %h required %h", wlog_addr[15], ea); end
    clr_model(); stall_en = 1;
    start_run(2'd0, 2'd2, 32'h1234, AW'(32'h200), BW'(8), 16'd4, 1'b0);
    repeat (6) tick();
    rst = 1'b1; #1;
    n_vec++; if ({write_o, read_o, busy_o, done_o} !== 4'b0 || address_o !== '0 || writedata_o !== '0 || byteenable_o !== '0) begin
      n_bad++; $display("FAIL midrun_reset: wr %b rd %b busy %b addr %h be %h required all 0", write_o, read_o, busy_o, address_o, byteenable_o); end
    tick(); tick();
    rst = 1'b0;
    tick();
    clr_model();
    start_run(2'd2, 2'd0, 32'h0, AW'(32'h300), BW'(4), 16'd0, 1'b0);
    wait_done(10, seen);
    tick(); tick(); tick();
    n_vec++; if (!seen || n_done != 1 || wlog_addr.size() != 0 || n_rd_acc != 0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL zero_cnt: seen %b done %0d writes %0d reads %0d busy %b required 1 1 0 0 0", seen, n_done, wlog_addr.size(), n_rd_acc, busy_o); end
  endtask

  task automatic test_random();
    bit seen;
    logic [1:0] m, p;
    logic [31:0] s;
    logic [AW-1:0] b, ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] l;
    logic [15:0] c;
    int unsigned leff, n, nw;
    for (int it = 0; it < 6; it++) begin
      clr_model();
      m = 2'($urandom_range(0, 3)); p = 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      b = (it % 2 == 0) ? AW'(32'h7FFF_FFF8 + $urandom_range(0, 7)) : AW'($urandom);
      l = BW'($urandom_range(0, 6)); c = 16'($urandom_range(1, 5));
      stall_en = 1'($urandom_range(0, 1)); lat = $urandom_range(1, 8);
      leff = (l == 0) ? 1 : int'(l);
      n = leff * int'(c);
      prefill(int'(p), s, b, n);
      start_run(m, p, s, b, l, c, 1'b0);
      wait_done(3000, seen);
      nw = (m == 2'd1) ? 0 : n;
      n_vec++; if (!seen || error_o !== 1'b0 || err_cnt_o !== 32'd0) begin
        n_bad++; $display("FAIL rand%0d_status: seen %b err %b cnt %0d required 1 0 0", it, seen, error_o, err_cnt_o); end
      n_vec++; if (wlog_addr.size() != nw || n_beats != ((m == 2'd0) ? 0 : n) || max_out > MRO) begin
        n_bad++; $display("FAIL rand%0d_counts: writes %0d beats %0d peak %0d required %0d %0d <=%0d", it, wlog_addr.size(), n_beats, max_out, nw, (m == 2'd0) ? 0 : n, MRO); end
      for (int unsigned i = 0; i < wlog_addr.size() && i < nw; i++) begin
        ea = b + AW'(i); ed = {4{ref_lane(int'(p), s, b, i)}};
        n_vec++; if (wlog_addr[i] !== ea || wlog_data[i] !== ed) begin
          n_bad++; $display("FAIL rand%0d_wr[%0d]: got %h/%h required %h/%h", it, i, wlog_addr[i], wlog_data[i], ea, ed); end
      end
      tick(); tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read_ideal();
    test_corrupt_word();
    test_outstanding();
    test_lfsr_stall();
    test_stop_on_err();
    test_busy_reset_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
